// File: rtl/riscv_fetch_ctrl_pkg.sv
// rtl/riscv_fetch_ctrl_pkg.sv - shared fetch-stage types and constants
package riscv_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INS_NOP = 32'h0000_0013;

endpackage

// File: rtl/riscv_fetch_buf.sv
// rtl/riscv_fetch_buf.sv - circular instruction FIFO with flush; head word read straight from storage registers
module riscv_fetch_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [PTR_W:0]    count_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    assign w_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign w_pop   = pop_i && (r_count != '0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_push  = push_i && (!w_full || w_pop);
    assign valid_o = (r_count != '0);
    assign data_o  = r_mem[r_rptr];
    assign count_o = r_count;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= push_data_i;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);
        end
    end

endmodule

// File: rtl/riscv_fetch_ctrl.sv
// rtl/riscv_fetch_ctrl.sv - IF-stage sequencer: steers riscv_pc, issues one imem request at a time, buffers words for decode
module riscv_fetch_ctrl
    import riscv_fetch_ctrl_pkg::*;
#(
    parameter int PC_SIZE   = 32,
    parameter int INS_WIDTH = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [PC_SIZE-1:0]   pc_addr_i,
    output logic                 ird_o,
    output logic                 branch_taken_o,
    output logic [PC_SIZE-1:0]   jump_addr_o,
    output logic                 imem_req_o,
    output logic [PC_SIZE-1:0]   imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [INS_WIDTH-1:0] imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [PC_SIZE-1:0]   redirect_addr_i,
    input  logic                 halt_i,
    output logic                 ins_valid_o,
    input  logic                 ins_ready_i,
    output logic [INS_WIDTH-1:0] ins_data_o,
    output logic [PC_SIZE-1:0]   ins_pc_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int BUF_W = INS_WIDTH + PC_SIZE;

    fetch_state_e       r_state;
    logic               r_req;
    logic [PC_SIZE-1:0] r_req_pc;
    logic               r_pend;
    logic [PC_SIZE-1:0] r_pend_addr;
    logic               r_kill;

    logic               w_ird;
    logic               w_rsp;
    logic               w_push;
    logic               w_pop;
    logic               w_go;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_next_count;
    logic [PC_SIZE-1:0] w_jump;
    logic [BUF_W-1:0]   w_head;

    assign w_ird  = r_req && imem_gnt_i;
    assign w_rsp  = (r_state == FS_WAIT) && imem_rvalid_i;
    assign w_push = w_rsp && !r_kill;
    assign w_pop  = ins_valid_o && ins_ready_i;

    // Occupancy after this edge; a redirect empties the buffer regardless of push/pop.
    assign w_next_count = redirect_i ? '0 : (w_count + CNT_W'(w_push) - CNT_W'(w_pop));
    assign w_go         = !halt_i && (w_next_count < CNT_W'(BUF_DEPTH));

    assign ird_o          = w_ird;
    assign imem_req_o     = r_req;
    assign imem_addr_o    = r_req ? pc_addr_i : '0;
    assign branch_taken_o = r_pend || redirect_i;
    assign w_jump         = redirect_i ? redirect_addr_i : r_pend_addr;
    assign jump_addr_o    = {w_jump[PC_SIZE-1:2], 2'b00};
    assign ins_data_o     = w_head[BUF_W-1:PC_SIZE];
    assign ins_pc_o       = w_head[PC_SIZE-1:0];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= FS_IDLE;
            r_req    <= 1'b0;
            r_req_pc <= '0;
        end else begin
            case (r_state)
                FS_IDLE: begin
                    if (w_go) begin
                        r_state <= FS_REQ;
                        r_req   <= 1'b1;
                    end
                end
                FS_REQ: begin
                    if (imem_gnt_i) begin
                        r_state  <= FS_WAIT;
                        r_req    <= 1'b0;
                        r_req_pc <= pc_addr_i;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid_i) begin
                        r_state <= w_go ? FS_REQ : FS_IDLE;
                        r_req   <= w_go;
                    end
                end
                default: begin
                    r_state <= FS_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // A redirect granted in the same cycle is already consumed by the PC, so ird wins over setting pend.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_kill      <= 1'b0;
        end else begin
            if (w_ird) begin
                r_pend <= 1'b0;
            end else if (redirect_i) begin
                r_pend <= 1'b1;
            end
            if (redirect_i) begin
                r_pend_addr <= redirect_addr_i;
            end
            if (w_rsp) begin
                r_kill <= 1'b0;
            end else if ((r_state == FS_WAIT) && redirect_i) begin
                r_kill <= 1'b1;
            end
        end
    end

    riscv_fetch_buf #(
        .DATA_W (BUF_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (redirect_i),
        .push_i      (w_push),
        .push_data_i ({imem_rdata_i, r_req_pc}),
        .pop_i       (w_pop),
        .valid_o     (ins_valid_o),
        .data_o      (w_head),
        .count_o     (w_count)
    );

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// tb/tb_riscv_fetch_ctrl.sv - scoreboard bench for riscv_fetch_ctrl with PC and imem models
module tb_riscv_fetch_ctrl;

    localparam int PC_SIZE   = 32;
    localparam int INS_WIDTH = 32;
    localparam int BUF_DEPTH = 2;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic [PC_SIZE-1:0]   pc_addr_i;
    logic                 ird_o;
    logic                 branch_taken_o;
    logic [PC_SIZE-1:0]   jump_addr_o;
    logic                 imem_req_o;
    logic [PC_SIZE-1:0]   imem_addr_o;
    logic                 imem_gnt_i;
    logic                 imem_rvalid_i;
    logic [INS_WIDTH-1:0] imem_rdata_i;
    logic                 redirect_i;
    logic [PC_SIZE-1:0]   redirect_addr_i;
    logic                 halt_i;
    logic                 ins_valid_o;
    logic                 ins_ready_i;
    logic [INS_WIDTH-1:0] ins_data_o;
    logic [PC_SIZE-1:0]   ins_pc_o;

    always #5 clk_i = ~clk_i;

    riscv_fetch_ctrl #(
        .PC_SIZE   (PC_SIZE),
        .INS_WIDTH (INS_WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .pc_addr_i       (pc_addr_i),
        .ird_o           (ird_o),
        .branch_taken_o  (branch_taken_o),
        .jump_addr_o     (jump_addr_o),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .halt_i          (halt_i),
        .ins_valid_o     (ins_valid_o),
        .ins_ready_i     (ins_ready_i),
        .ins_data_o      (ins_data_o),
        .ins_pc_o        (ins_pc_o)
    );

    int vectors    = 0;
    int miscompares = 0;
    int grants     = 0;
    int pops       = 0;
    int fixed_lat  = 0;
    logic force_rv = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] n_exp = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Program counter: next address is the redirect target when branch_taken, advances on ird.
    logic [31:0] m_pc;
    assign pc_addr_i = branch_taken_o ? jump_addr_o : m_pc;
    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) m_pc <= 32'h0;
        else if (ird_o) m_pc <= pc_addr_i + 32'd4;
    end

    // Instruction memory: one response per grant after 1..3 cycles.
    logic        r_rv;
    logic [31:0] r_rd;
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_addr;
    assign imem_rvalid_i = r_rv | force_rv;
    assign imem_rdata_i  = force_rv ? 32'hDEAD_BEEF : r_rd;

    always @(posedge clk_i or negedge reset_i) begin
        int lat;
        if (!reset_i) begin
            m_pend = 1'b0;
            r_rv  <= 1'b0;
            r_rd  <= 32'h0;
        end else begin
            r_rv <= 1'b0;
            if (m_pend) begin
                if (m_cnt == 0) begin
                    r_rv  <= 1'b1;
                    r_rd  <= mem_word(m_addr);
                    m_pend = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            if (imem_req_o && imem_gnt_i) begin
                grants++;
                lat    = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
                m_addr = imem_addr_o;
                if (lat == 1) begin
                    r_rv <= 1'b1;
                    r_rd <= mem_word(imem_addr_o);
                end else begin
                    m_pend = 1'b1;
                    m_cnt  = lat - 2;
                end
            end
        end
    end

    // Monitor: consumed instructions against the expected PC stream, plus request hold rules.
    logic        p_req;
    logic        p_gnt;
    logic [31:0] p_addr;
    always @(negedge clk_i) begin
        if (!reset_i) begin
            p_req = 1'b0;
            p_gnt = 1'b0;
        end else begin
            if (!imem_gnt_i) check("ird_without_gnt", {31'h0, ird_o}, 32'h0);
            if (p_req && !p_gnt && !redirect_i) begin
                check("req_held", {31'h0, imem_req_o}, 32'h1);
                check("addr_held", imem_addr_o, p_addr);
            end
            if (ins_valid_o && ins_ready_i && !redirect_i) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("exp_queue_empty", 32'h1, 32'h0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("ins_pc", ins_pc_o, e);
                    check("ins_data", ins_data_o, mem_word(e));
                end
            end
            p_req  = imem_req_o;
            p_gnt  = imem_gnt_i;
            p_addr = imem_addr_o;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        while (exp_q.size() < 8) begin
            exp_q.push_back(n_exp);
            n_exp = n_exp + 32'd4;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect_i      = 1'b1;
        redirect_addr_i = a;
        exp_q.delete();
        n_exp = a & ~32'h3;
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (!imem_req_o && k < 50) begin
            step();
            k++;
        end
        if (!imem_req_o) check("wait_req_timeout", 32'h0, 32'h1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"}, {31'h0, imem_req_o}, 32'h0);
        check({tag, "_ird"}, {31'h0, ird_o}, 32'h0);
        check({tag, "_valid"}, {31'h0, ins_valid_o}, 32'h0);
        check({tag, "_bt"}, {31'h0, branch_taken_o}, 32'h0);
        check({tag, "_addr"}, imem_addr_o, 32'h0);
        check({tag, "_jump"}, jump_addr_o, 32'h0);
        check({tag, "_pc"}, ins_pc_o, 32'h0);
        check({tag, "_data"}, ins_data_o, 32'h0);
    endtask

    // Hold reset, then release with a stray rvalid in the first cycle (IDLE must ignore it).
    task automatic do_reset();
        reset_i    = 1'b0;
        redirect_i = 1'b0;
        halt_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        grants = 0;
        pops   = 0;
        exp_q.delete();
        n_exp = 32'h0;
        reset_i  = 1'b1;
        force_rv = 1'b1;
        step();
        force_rv = 1'b0;
    endtask

    initial begin
        logic [31:0] a0;
        logic [31:0] pc0;
        reset_i         = 1'b0;
        imem_gnt_i      = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = 32'h0;
        halt_i          = 1'b0;
        ins_ready_i     = 1'b0;
        #12;
        check_quiet("reset");

        // Sequential fetch with an always-ready decode.
        imem_gnt_i  = 1'b1;
        ins_ready_i = 1'b1;
        fixed_lat   = 1;
        do_reset();
        run(14);
        check("t1_pops", {31'h0, pops >= 3}, 32'h1);

        // Decode stalled: buffer fills to BUF_DEPTH and fetching stops.
        ins_ready_i = 1'b0;
        run(14);
        check("t2_req_idle", {31'h0, imem_req_o}, 32'h0);
        check("t2_valid", {31'h0, ins_valid_o}, 32'h1);
        check("t2_buffered", grants - pops, BUF_DEPTH);
        ins_ready_i = 1'b1;
        run(10);

        // Redirect while a response is outstanding: stale word dropped.
        fixed_lat = 3;
        wait_req();
        step();
        do_redirect(32'h100);
        step();
        redirect_i = 1'b0;
        check("t3_flushed", {31'h0, ins_valid_o}, 32'h0);
        run(12);

        // Grant stall with a redirect in the middle of it.
        fixed_lat  = 1;
        imem_gnt_i = 1'b0;
        wait_req();
        a0  = imem_addr_o;
        pc0 = m_pc;
        run(2);
        check("t4_addr_stable", imem_addr_o, a0);
        check("t4_pc_hold", m_pc, pc0);
        do_redirect(32'h200);
        step();
        redirect_i = 1'b0;
        check("t4_addr_target", imem_addr_o, 32'h200);
        imem_gnt_i = 1'b1;
        run(10);

        // Misaligned target and back-to-back redirects.
        do_redirect(32'h303);
        #1;
        check("t5_jump_mask", jump_addr_o, 32'h300);
        check("t5_bt", {31'h0, branch_taken_o}, 32'h1);
        step();
        do_redirect(32'h40);
        step();
        do_redirect(32'h80);
        step();
        redirect_i = 1'b0;
        run(12);

        // Asynchronous reset while waiting on imem.
        fixed_lat = 3;
        wait_req();
        step();
        #2;
        reset_i = 1'b0;
        #1;
        check_quiet("async_reset");
        do_reset();

        // Halt in WAIT: the in-flight word is delivered, nothing new is requested.
        fixed_lat = 2;
        wait_req();
        step();
        halt_i = 1'b1;
        run(10);
        check("t6_halt_req", {31'h0, imem_req_o}, 32'h0);
        check("t6_halt_drain", {31'h0, ins_valid_o}, 32'h0);
        check("t6_halt_words", grants, pops);
        check("t6_halt_any", {31'h0, pops >= 1}, 32'h1);
        halt_i = 1'b0;

        // Randomised traffic.
        fixed_lat = 0;
        pops      = 0;
        for (int i = 0; i < 1500; i++) begin
            imem_gnt_i  = ($urandom_range(0, 3) != 0);
            ins_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) halt_i = ~halt_i;
            if ($urandom_range(0, 19) == 0) do_redirect($urandom & 32'h0000_0FFF);
            else redirect_i = 1'b0;
            step();
        end
        redirect_i  = 1'b0;
        halt_i      = 1'b0;
        imem_gnt_i  = 1'b1;
        ins_ready_i = 1'b1;
        run(20);
        check("random_progress", {31'h0, pops > 50}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
